// File: rtl/bk_adder_arbiter.sv
// rtl/bk_adder_arbiter.sv - round-robin arbiter sharing one Brent-Kung adder
//
// brent_kung_adder
//   32-bit parallel-prefix adder with carry-in.
//   a_i, b_i   operands
//   cin_i      carry into bit 0
//   sum_o      a_i + b_i + cin_i modulo 2^32
//   cout_o     carry out of bit 31
//
// bk_adder_arbiter
//   Shares one brent_kung_adder between N_REQ requesters. Requesters are
//   granted round-robin. One registered response slot carries the result
//   together with the requester id, so one add completes per cycle.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational)
//   req_a      operand A, requester i at [32*i+31:32*i]
//   req_b      operand B, same packing
//   req_cin    per-requester carry-in
//   rsp_valid  response valid
//   rsp_ready  downstream accepts the response
//   rsp_sum    registered sum
//   rsp_cout   registered carry-out
//   rsp_ovf    registered signed overflow
//   rsp_id     index of the requester that produced the response

module brent_kung_adder (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   always_comb begin
      logic [31:0] p0;
      logic [31:0] g;
      logic [31:0] p;
      p0 = a_i ^ b_i;
      g  = a_i & b_i;
      p  = p0;
      // Fold the carry-in into bit 0 so every prefix G[i] is the carry into bit i+1.
      g[0] = g[0] | (p0[0] & cin_i);

      // Up-sweep: build group (G,P) at indices 2^(l+1)-1 modulo 2^(l+1).
      for (int l = 0; l < 5; l++) begin
         for (int i = 0; i < 32; i++) begin
            if ((i % (2 << l)) == ((2 << l) - 1)) begin
               g[i] = g[i] | (p[i] & g[i - (1 << l)]);
               p[i] = p[i] & p[i - (1 << l)];
            end
         end
      end

      // Down-sweep: fill in the remaining prefixes from the already-complete ones.
      for (int l = 3; l >= 0; l--) begin
         for (int i = 0; i < 32; i++) begin
            if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (1 << l))) begin
               g[i] = g[i] | (p[i] & g[i - (1 << l)]);
               p[i] = p[i] & p[i - (1 << l)];
            end
         end
      end

      sum_o  = p0 ^ {g[30:0], cin_i};
      cout_o = g[31];
   end

endmodule

module bk_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*32-1:0]   req_a,
   input  logic [N_REQ*32-1:0]   req_b,
   input  logic [N_REQ-1:0]      req_cin,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic [ID_W-1:0]       rsp_id
);

   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_sum_q,   rsp_sum_d;
   logic            rsp_cout_q,  rsp_cout_d;
   logic            rsp_ovf_q,   rsp_ovf_d;
   logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
   logic [ID_W-1:0] ptr_q,       ptr_d;

   logic            can_accept;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic            accept;
   logic [31:0]     add_a;
   logic [31:0]     add_b;
   logic            add_cin;
   logic [31:0]     add_sum;
   logic            add_cout;

   assign can_accept = !rsp_valid_q || rsp_ready;

   // Round-robin search starting at ptr_q; the first valid requester wins.
   always_comb begin
      logic [ID_W-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = ID_W'((int'(ptr_q) + off) % N_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // rst_n gates the grant so nothing is offered while the block is held in reset.
   assign accept = grant_found && can_accept && rst_n;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      add_a   = req_a[31:0];
      add_b   = req_b[31:0];
      add_cin = req_cin[0];
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            add_a   = req_a[32*i +: 32];
            add_b   = req_b[32*i +: 32];
            add_cin = req_cin[i];
         end
      end
   end

   brent_kung_adder u_adder (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_ovf_d   = rsp_ovf_q;
      rsp_id_d    = rsp_id_q;
      ptr_d       = ptr_q;
      if (accept) begin
         // Also covers a same-cycle response handshake: the slot is refilled with no bubble.
         rsp_valid_d = 1'b1;
         rsp_sum_d   = add_sum;
         rsp_cout_d  = add_cout;
         rsp_ovf_d   = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
         rsp_id_d    = grant_idx;
         ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_ovf_q   <= 1'b0;
         rsp_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_ovf_q   <= rsp_ovf_d;
         rsp_id_q    <= rsp_id_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// tb/tb_bk_adder_arbiter.sv - directed self-checking bench for bk_adder_arbiter

module tb_bk_adder_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*32-1:0] req_a;
   logic [N_REQ*32-1:0] req_b;
   logic [N_REQ-1:0]    req_cin;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [31:0]         rsp_sum;
   logic                rsp_cout;
   logic                rsp_ovf;
   logic [ID_W-1:0]     rsp_id;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bk_adder_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf),
      .rsp_id    (rsp_id)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
      req_valid[i]      = 1'b1;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_cin[i]        = cin;
   endtask

   task automatic check_rsp(input string tag, input int id, input logic [31:0] sum,
                            input logic cout, input logic ovf);
      check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      check_eq({tag, "_id"},    64'(rsp_id),    64'(id));
      check_eq({tag, "_sum"},   64'(rsp_sum),   64'(sum));
      check_eq({tag, "_cout"},  64'(rsp_cout),  64'(cout));
      check_eq({tag, "_ovf"},   64'(rsp_ovf),   64'(ovf));
   endtask

   // Single request; called at a negedge, returns at the negedge after acceptance.
   task automatic issue_one(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic [31:0] sum, input logic cout, input logic ovf);
      set_req(i, a, b, cin);
      #1;
      check_eq({tag, "_ready"}, 64'(req_ready), 64'(1 << i));
      @(negedge clk);
      req_valid[i] = 1'b0;
      check_rsp(tag, i, sum, cout, ovf);
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b1;

      // Reset state, with a request present to show req_ready is gated.
      set_req(0, 32'd1, 32'd2, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_sum",   64'(rsp_sum),   64'd0);
      check_eq("rst_cout",  64'(rsp_cout),  64'd0);
      check_eq("rst_ovf",   64'(rsp_ovf),   64'd0);
      check_eq("rst_id",    64'(rsp_id),    64'd0);
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single requester.
      issue_one("t1", 0, 32'd103, 32'd166, 1'b0, 32'd269, 1'b0, 1'b0);

      // 2: all four valid together from ptr=0 -> back-to-back ids 0..3.
      apply_reset();
      set_req(0, 32'd79,   32'd156, 1'b0);
      set_req(1, 32'd222,  32'd993, 1'b0);
      set_req(2, 32'd149,  32'd502, 1'b0);
      set_req(3, 32'd1018, 32'd788, 1'b0);
      begin
         logic [31:0] exp_sum [4];
         exp_sum[0] = 32'd235;
         exp_sum[1] = 32'd1215;
         exp_sum[2] = 32'd651;
         exp_sum[3] = 32'd1806;
         for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("t2_ready%0d", k), 64'(req_ready), 64'(1 << k));
            @(negedge clk);
            req_valid[k] = 1'b0;
            check_rsp($sformatf("t2_rsp%0d", k), k, exp_sum[k], 1'b0, 1'b0);
         end
      end

      // 3: backpressure with req1 waiting.
      rsp_ready = 1'b0;
      set_req(1, 32'd5, 32'd7, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq($sformatf("t3_ready%0d", k), 64'(req_ready), 64'd0);
         check_rsp($sformatf("t3_hold%0d", k), 3, 32'd1806, 1'b0, 1'b0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check_eq("t3_ready_go", 64'(req_ready), 64'b0010);
      @(negedge clk);
      req_valid[1] = 1'b0;
      check_rsp("t3_rsp", 1, 32'd12, 1'b0, 1'b0);

      // 4: arithmetic boundaries.
      issue_one("t4_wrap",   0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      issue_one("t4_ovf",    0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      issue_one("t4_cin",    0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
      issue_one("t4_cinrip", 0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      issue_one("t4_negovf", 0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      issue_one("t4_mix",    0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
      issue_one("t4_mid",    0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

      // 5: rotation. req2 alone moves ptr to 3; then req3 beats req1.
      issue_one("t5_r2", 2, 32'd100, 32'd200, 1'b0, 32'd300, 1'b0, 1'b0);
      set_req(1, 32'd1,  32'd2,  1'b1);
      set_req(3, 32'd10, 32'd20, 1'b0);
      #1;
      check_eq("t5_ready3", 64'(req_ready), 64'b1000);
      @(negedge clk);
      req_valid[3] = 1'b0;
      check_rsp("t5_rsp3", 3, 32'd30, 1'b0, 1'b0);
      #1;
      check_eq("t5_ready1", 64'(req_ready), 64'b0010);
      @(negedge clk);
      req_valid[1] = 1'b0;
      check_rsp("t5_rsp1", 1, 32'd4, 1'b0, 1'b0);

      // 6: asynchronous reset while a response is stalled.
      rsp_ready = 1'b0;
      #1;
      check_eq("t6_pre_valid", 64'(rsp_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", 64'(rsp_valid), 64'd0);
      check_eq("t6_rst_sum",   64'(rsp_sum),   64'd0);
      set_req(0, 32'd3, 32'd4, 1'b0);
      set_req(3, 32'd6, 32'd7, 1'b0);
      #1;
      check_eq("t6_rst_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check_eq("t6_ready0", 64'(req_ready), 64'b0001);
      @(negedge clk);
      req_valid[0] = 1'b0;
      check_rsp("t6_rsp0", 0, 32'd7, 1'b0, 1'b0);
      #1;
      check_eq("t6_ready3", 64'(req_ready), 64'b1000);
      @(negedge clk);
      req_valid[3] = 1'b0;
      check_rsp("t6_rsp3", 3, 32'd13, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("t6_drain", 64'(rsp_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
